// File: rtl/mmio_uart_tx_if.sv
// CPU data-bus view of the memory-mapped UART transmitter.
// The master drives address, store data and strobe; the slave returns read data and hit.
interface mmio_uart_tx_if;
  logic [31:0] memory_address;
  logic [31:0] memory_write;
  logic        we;
  logic [31:0] read_data;
  logic        hit;

  modport master (
    output memory_address, memory_write, we,
    input  read_data, hit
  );

  modport slave (
    input  memory_address, memory_write, we,
    output read_data, hit
  );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// TXDATA at BASE+0 queues a byte; STATUS at BASE+4 reports FIFO state and sticky overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]    DEPTH5   = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [4:0]    count;
  logic          ovf;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic empty, full;
  logic wr_txdata, wr_status;
  logic push, pop, bit_end;
  logic unused_bits;

  assign unused_bits = ^{bus.memory_write[31:8], bus.memory_address[1:0]};

  assign bus.hit   = (bus.memory_address[31:3] == BASE_ADDR[31:3]);
  assign empty     = (count == 5'd0);
  assign full      = (count == DEPTH5);
  assign wr_txdata = bus.we & bus.hit & ~bus.memory_address[2];
  assign wr_status = bus.we & bus.hit &  bus.memory_address[2];
  assign push      = wr_txdata & ~full;
  assign bit_end   = (bit_cnt == BIT_LAST);
  // The FSM takes the head byte either from idle or on the last stop-bit cycle.
  assign pop       = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
  assign busy      = (state != IDLE) | ~empty;

  always_comb begin
    bus.read_data = '0;
    if (bus.hit && bus.memory_address[2])
      bus.read_data = {16'h0, 4'h0, count[3:0], 4'h0, ovf, empty, full, busy};
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr] <= bus.memory_write[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
      // Overflow set takes priority over a same-edge clear.
      ovf <= (ovf & ~(wr_status & bus.memory_write[3])) | (wr_txdata & full);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= fifo_mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
            bit_cnt <= '0;
            bit_idx <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
            bit_idx <= '0;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              shift   <= shift >> 1;
              tx      <= shift[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            if (pop) begin
              shift <= fifo_mem[rd_ptr];
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: a frame-timeline model of the UART checked every cycle,
// plus directed scenarios with literal expectations and a randomized bus phase.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: queued bytes, and the current frame as an elapsed-cycle count since its start bit.
  logic [7:0]  m_q[$];
  bit          m_active  = 1'b0;
  int          m_elapsed = 0;
  logic [7:0]  m_cur     = 8'h00;
  bit          m_ovf     = 1'b0;
  int          sz0;
  logic [31:0] off;
  bit          m_hit, set_o, clr_o;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_active  = 1'b0;
        m_elapsed = 0;
        m_ovf     = 1'b0;
      end else begin
        sz0 = m_q.size();
        if (m_active) begin
          m_elapsed++;
          if (m_elapsed == 10 * CPB) begin
            if (sz0 > 0) begin
              m_cur     = m_q.pop_front();
              m_elapsed = 0;
            end else begin
              m_active = 1'b0;
            end
          end
        end else if (sz0 > 0) begin
          m_cur     = m_q.pop_front();
          m_active  = 1'b1;
          m_elapsed = 0;
        end
        off   = bus.memory_address - BASE;
        m_hit = (off < 32'd8);
        set_o = 1'b0;
        clr_o = 1'b0;
        if (bus.we && m_hit && off < 32'd4) begin
          if (sz0 == DEPTH) set_o = 1'b1;
          else              m_q.push_back(bus.memory_write[7:0]);
        end
        if (bus.we && m_hit && off >= 32'd4 && bus.memory_write[3]) clr_o = 1'b1;
        if (clr_o) m_ovf = 1'b0;
        if (set_o) m_ovf = 1'b1;
      end
    end
  end

  function automatic logic exp_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_elapsed / CPB;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  function automatic logic exp_busy();
    return m_active || (m_q.size() > 0);
  endfunction

  function automatic logic exp_hit();
    logic [31:0] o;
    o = bus.memory_address - BASE;
    return o < 32'd8;
  endfunction

  function automatic logic [31:0] exp_rd();
    logic [31:0] o;
    int n;
    o = bus.memory_address - BASE;
    if (o < 32'd4 || o >= 32'd8) return 32'h0;
    n = m_q.size();
    return 32'(n * 256 + int'(m_ovf) * 8 + (n == 0 ? 4 : 0)
               + (n == DEPTH ? 2 : 0) + int'(exp_busy()));
  endfunction

  always @(negedge clk) begin
    check("tx",        {31'h0, tx},   {31'h0, exp_tx()});
    check("busy",      {31'h0, busy}, {31'h0, exp_busy()});
    check("hit",       {31'h0, bus.hit}, {31'h0, exp_hit()});
    check("read_data", bus.read_data, exp_rd());
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    bus.memory_address = a;
    bus.memory_write   = d;
    bus.we             = 1'b1;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  logic [9:0]  frame55;
  logic [31:0] rnd_addr;

  initial begin
    reset              = 1'b1;
    bus.we             = 1'b0;
    bus.memory_address = '0;
    bus.memory_write   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    bus.memory_address = BASE + 32'd4;
    @(negedge clk);
    check("t1_status", bus.read_data, 32'h0000_0004);
    check("t1_tx",     {31'h0, tx},   32'h1);
    check("t1_busy",   {31'h0, busy}, 32'h0);

    // Single byte 0x55: start, LSB-first data, stop
    frame55 = 10'b1010101010;
    store(BASE, 32'h55);
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("t2_tx_%0d", k), {31'h0, tx}, {31'h0, frame55[(k-1)/CPB]});
    end
    @(posedge clk);
    @(negedge clk);
    check("t2_busy_end", {31'h0, busy}, 32'h0);
    check("t2_tx_end",   {31'h0, tx},   32'h1);

    // Overfill: six back-to-back stores
    for (int i = 1; i <= 6; i++) store(BASE, 32'(i));
    bus.memory_address = BASE + 32'd4;
    @(negedge clk);
    check("t3_status", bus.read_data, 32'h0000_040B);
    store(BASE + 32'd4, 32'h0);
    @(negedge clk);
    check("t4_ovf_kept", (bus.read_data >> 3) & 32'h1, 32'h1);
    store(BASE + 32'd4, 32'h8);
    @(negedge clk);
    check("t4_ovf_clr", (bus.read_data >> 3) & 32'h1, 32'h0);
    repeat (193) @(posedge clk);
    @(negedge clk);
    check("t3_busy_last", {31'h0, busy}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("t3_busy_done", {31'h0, busy}, 32'h0);

    // Reset in the middle of a frame
    store(BASE, 32'hA5);
    repeat (11) @(posedge clk);
    #2;
    check("t5_tx_before", {31'h0, tx}, 32'h0);
    reset = 1'b1;
    #1;
    check("t5_tx_reset", {31'h0, tx}, 32'h1);
    @(posedge clk);
    #1 reset = 1'b0;
    bus.memory_address = BASE + 32'd4;
    @(negedge clk);
    check("t5_status", bus.read_data, 32'h0000_0004);
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("t5_tx_quiet",   {31'h0, tx},   32'h1);
    check("t5_busy_quiet", {31'h0, busy}, 32'h0);

    // Address decode
    store(BASE + 32'd8, 32'h77);
    @(negedge clk);
    check("t6_hit_b8", {31'h0, bus.hit}, 32'h0);
    check("t6_rd_b8",  bus.read_data,    32'h0);
    store(32'h0, 32'h77);
    @(negedge clk);
    check("t6_hit_0", {31'h0, bus.hit}, 32'h0);
    check("t6_rd_0",  bus.read_data,    32'h0);
    bus.memory_address = BASE + 32'd4;
    #1;
    check("t6_status_empty", bus.read_data, 32'h0000_0004);
    store(BASE + 32'd1, 32'h3C);
    @(negedge clk);
    check("t6_hit_b1", {31'h0, bus.hit}, 32'h1);
    check("t6_rd_b1",  bus.read_data,    32'h0);
    bus.memory_address = BASE + 32'd4;
    #1;
    check("t6_status_one", bus.read_data, 32'h0000_0101);
    repeat (45) @(posedge clk);
    #1;

    // Randomized bus traffic against the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: rnd_addr = BASE + 32'($urandom_range(0, 3));
        3:       rnd_addr = BASE + 32'd4 + 32'($urandom_range(0, 3));
        4:       rnd_addr = ($urandom_range(0, 1) == 0) ? BASE + 32'd8 : BASE - 32'd4;
        default: rnd_addr = $urandom;
      endcase
      bus.memory_address = rnd_addr;
      bus.memory_write   = $urandom;
      bus.we             = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 999) == 0) begin
        #2 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.we = 1'b0;
    bus.memory_address = BASE + 32'd4;
    repeat (600) @(posedge clk);
    @(negedge clk);
    check("end_busy", {31'h0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
